// File: rtl/gf2m_pkg.sv
// Field constants and FSM encoding for the GF(2^m) multiplier/divider pair.
// Bit i of every polynomial vector is the coefficient of x^i.
package gf2m_pkg;

  localparam int unsigned M  = 16;
  localparam int unsigned K2 = 5;
  localparam int unsigned K1 = 3;
  localparam int unsigned K0 = 2;

  // f(x) = x^16 + x^5 + x^3 + x^2 + 1
  localparam logic [M:0] F_POLY = 17'h1002D;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

endpackage

// File: rtl/gf2m_divider_halve.sv
// Combinational g * x^-1 mod f(x), where f = x^m + x^k2 + x^k1 + x^k0 + 1.
module gf2m_halve #(
  parameter int unsigned M  = 16,
  parameter int unsigned K2 = 5,
  parameter int unsigned K1 = 3,
  parameter int unsigned K0 = 2
) (
  input  logic [M-1:0] i_g,
  output logic [M-1:0] o_g
);

  // Odd g: (g ^ f) >> 1 sets the top bit and flips the shifted middle terms.
  always_comb begin
    o_g = i_g >> 1;
    if (i_g[0]) begin
      o_g[M-1]  = 1'b1;
      o_g[K2-1] = ~o_g[K2-1];
      o_g[K1-1] = ~o_g[K1-1];
      o_g[K0-1] = ~o_g[K0-1];
    end
  end

endmodule

// File: rtl/gf2m_divider.sv
// Multi-cycle GF(2^m) divider C = A * B^-1 mod f using the binary extended
// Euclidean algorithm, one reduction step per cycle, valid/ready on both sides.
module gf2m_divider
  import gf2m_pkg::*;
#(
  parameter int unsigned m  = M,
  parameter int unsigned k2 = K2,
  parameter int unsigned k1 = K1,
  parameter int unsigned k0 = K0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:m-1] A_in,
  input  logic [0:m-1] B_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:m-1] C_out,
  output logic         div_by_zero
);

  localparam logic [m:0] ONE_V = {{m{1'b0}}, 1'b1};
  localparam logic [m:0] F     = (ONE_V << m) | (ONE_V << k2) | (ONE_V << k1)
                               | (ONE_V << k0) | ONE_V;
  localparam logic [m-1:0] ONE_U = {{(m-1){1'b0}}, 1'b1};

  state_t       r_state, r_state_nxt;
  logic [m-1:0] r_u, r_u_nxt;
  logic [m:0]   r_v, r_v_nxt;
  logic [m-1:0] r_g1, r_g1_nxt;
  logic [m-1:0] r_g2, r_g2_nxt;
  logic [m-1:0] r_c, r_c_nxt;
  logic         r_dz, r_dz_nxt;

  logic [m-1:0] w_a, w_b;
  logic [m-1:0] w_g1_half, w_g2_half;

  // Port vectors are [0:m-1]; index i is the x^i coefficient on both sides.
  always_comb begin
    w_a = '0;
    w_b = '0;
    C_out = '0;
    for (int unsigned i = 0; i < m; i++) begin
      w_a[i]   = A_in[i];
      w_b[i]   = B_in[i];
      C_out[i] = r_c[i];
    end
  end

  gf2m_halve #(.M(m), .K2(k2), .K1(k1), .K0(k0)) u_halve_g1 (
    .i_g (r_g1),
    .o_g (w_g1_half)
  );

  gf2m_halve #(.M(m), .K2(k2), .K1(k1), .K0(k0)) u_halve_g2 (
    .i_g (r_g2),
    .o_g (w_g2_half)
  );

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign div_by_zero = r_dz;

  always_comb begin
    r_state_nxt = r_state;
    r_u_nxt     = r_u;
    r_v_nxt     = r_v;
    r_g1_nxt    = r_g1;
    r_g2_nxt    = r_g2;
    r_c_nxt     = r_c;
    r_dz_nxt    = r_dz;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_b == '0) begin
            r_c_nxt     = '0;
            r_dz_nxt    = 1'b1;
            r_state_nxt = S_DONE;
          end else begin
            r_u_nxt     = w_b;
            r_v_nxt     = F;
            r_g1_nxt    = w_a;
            r_g2_nxt    = '0;
            r_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        // Integer compare stands in for degree compare; on equal degrees
        // either reduction keeps the invariants.
        if (r_u == ONE_U) begin
          r_c_nxt     = r_g1;
          r_state_nxt = S_DONE;
        end else if (r_v == ONE_V) begin
          r_c_nxt     = r_g2;
          r_state_nxt = S_DONE;
        end else if (!r_u[0]) begin
          r_u_nxt  = r_u >> 1;
          r_g1_nxt = w_g1_half;
        end else if (!r_v[0]) begin
          r_v_nxt  = r_v >> 1;
          r_g2_nxt = w_g2_half;
        end else if ({1'b0, r_u} > r_v) begin
          r_u_nxt  = r_u ^ r_v[m-1:0];
          r_g1_nxt = r_g1 ^ r_g2;
        end else begin
          r_v_nxt  = r_v ^ {1'b0, r_u};
          r_g2_nxt = r_g2 ^ r_g1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          r_dz_nxt    = 1'b0;
          r_state_nxt = S_IDLE;
        end
      end
      default: r_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_u     <= '0;
      r_v     <= '0;
      r_g1    <= '0;
      r_g2    <= '0;
      r_c     <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      r_u     <= r_u_nxt;
      r_v     <= r_v_nxt;
      r_g1    <= r_g1_nxt;
      r_g2    <= r_g2_nxt;
      r_c     <= r_c_nxt;
      r_dz    <= r_dz_nxt;
    end
  end

endmodule

// File: tb/tb_gf2m_divider.sv
// Directed and random checks of gf2m_divider against a behavioural GF(2^16)
// multiplier; hex operands are integers whose bit i is the x^i coefficient.
module tb_gf2m_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [0:15] A_in;
  logic [0:15] B_in;
  logic        out_valid;
  logic        out_ready;
  logic [0:15] C_out;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  gf2m_divider #(.m(16), .k2(5), .k1(3), .k0(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A_in        (A_in),
    .B_in        (B_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .C_out       (C_out),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [0:15] to_port(input logic [15:0] x);
    logic [0:15] r;
    for (int i = 0; i < 16; i++) r[i] = x[i];
    return r;
  endfunction

  function automatic logic [15:0] from_port(input logic [0:15] p);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = p[i];
    return r;
  endfunction

  function automatic logic [15:0] gmul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic [31:0] f;
    p = '0;
    f = 32'h0001002D;
    for (int i = 0; i < 16; i++)
      if (b[i]) p = p ^ ({16'h0, a} << i);
    for (int i = 31; i >= 16; i--)
      if (p[i]) p = p ^ (f << (i - 16));
    return p[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair and wait for out_valid; lat counts edges from the
  // accept edge (accept edge itself = 1).
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] c, output logic dz, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin tick(); w++; end
    check("in_ready_before_issue", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1;
    A_in = to_port(a);
    B_in = to_port(b);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    c  = from_port(C_out);
    dz = div_by_zero;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_hs_out_valid", {31'h0, out_valid}, 32'h0);
    check("post_hs_in_ready", {31'h0, in_ready}, 32'h1);
    check("post_hs_dz", {31'h0, div_by_zero}, 32'h0);
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_c);
    logic [15:0] c;
    logic        dz;
    int          lat;
    issue(a, b, c, dz, lat);
    check({tag, "_C"}, {16'h0, c}, {16'h0, exp_c});
    check({tag, "_dz"}, {31'h0, dz}, 32'h0);
    check({tag, "_lat_le64"}, {31'h0, (lat <= 64)}, 32'h1);
    handshake();
  endtask

  initial begin
    logic [15:0] a, b, c, c_hold;
    logic        dz;
    int          lat;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A_in = '0;
    B_in = '0;
    tick();
    tick();
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_C", {16'h0, from_port(C_out)}, 32'h0);
    check("rst_dz", {31'h0, div_by_zero}, 32'h0);
    rst_n = 1'b1;
    tick();

    // B = 1: one RUN cycle, result two edges after accept
    issue(16'h0001, 16'h0001, c, dz, lat);
    check("one_C", {16'h0, c}, 32'h0001);
    check("one_dz", {31'h0, dz}, 32'h0);
    check("one_lat", lat, 2);
    handshake();

    directed("xinv", 16'h0001, 16'h0002, 16'h8016);
    directed("x2_div_x", 16'h0004, 16'h0002, 16'h0002);
    directed("self", 16'h1234, 16'h1234, 16'h0001);
    directed("zero_num", 16'h0000, 16'hBEEF, 16'h0000);

    issue(16'hFFFF, 16'h0000, c, dz, lat);
    check("dbz_C", {16'h0, c}, 32'h0);
    check("dbz_flag", {31'h0, dz}, 32'h1);
    check("dbz_lat", lat, 1);
    handshake();

    // Backpressure: result and status frozen, new operands ignored
    issue(16'h0004, 16'h0002, c_hold, dz, lat);
    check("bp_first_C", {16'h0, c_hold}, 32'h0002);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      A_in = to_port(16'h5555);
      B_in = to_port(16'h0000);
      tick();
      check("bp_out_valid", {31'h0, out_valid}, 32'h1);
      check("bp_in_ready", {31'h0, in_ready}, 32'h0);
      check("bp_C_stable", {16'h0, from_port(C_out)}, 32'h0002);
      check("bp_dz_stable", {31'h0, div_by_zero}, 32'h0);
    end
    in_valid = 1'b0;
    handshake();

    for (int n = 0; n < 400; n++) begin
      a = 16'($urandom);
      b = 16'($urandom_range(1, 65535));
      if (n % 40 == 7) begin
        in_valid = 1'b1;
        A_in = to_port(a);
        B_in = to_port(b);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < (n % 3); k++) tick();
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", {31'h0, in_ready}, 32'h1);
        check("abort_out_valid", {31'h0, out_valid}, 32'h0);
        check("abort_C", {16'h0, from_port(C_out)}, 32'h0);
        check("abort_dz", {31'h0, div_by_zero}, 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
          tick();
          check("no_stale_valid", {31'h0, out_valid}, 32'h0);
        end
      end else begin
        issue(a, b, c, dz, lat);
        check("rand_mul_back", {16'h0, gmul(c, b)}, {16'h0, a});
        check("rand_dz", {31'h0, dz}, 32'h0);
        check("rand_lat_le64", {31'h0, (lat <= 64)}, 32'h1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("rand_hs_in_ready", {31'h0, in_ready}, 32'h1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
